i2c_register_poller: RTL and testbench

- Upstream control stage for i2c_master. It repeatedly sweeps a contiguous block of 8-bit registers on one 7-bit I2C device.
- Each register read is a write of the register pointer, then a separate single-byte read transaction. Each captured byte goes out on a valid-strobed result port for display or consumer logic.
- Replaces hand-written per-design polling FSMs in top-level files.

---
 rtl/i2c_poller_pkg.sv | 24 ++
 rtl/poll_interval_timer.sv | 32 +++
 rtl/i2c_register_poller.sv | 181 ++++++++++++++++++
 tb/tb_i2c_register_poller.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_poller_pkg.sv
// Shared types and constants for the I2C register poller.
//   state_t    : poller FSM states
//   MODE_*     : R/W bit appended to the 7-bit device address
//   min1_clog2 : address width for a count of items, never below 1 bit
package i2c_poller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    RETRY,
    REPORT
  } state_t;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/poll_interval_timer.sv
// Loadable down-counter with a zero flag. Counts down by one per clock while
// non-zero and holds at zero. A load takes priority over counting.
//   clk_in     : clock
//   reset      : asynchronous, active-high; clears the count to zero
//   load       : load load_value this cycle
//   load_value : value to load
//   zero       : count is zero
module poll_interval_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/i2c_register_poller.sv
// Periodically sweeps NUM_REGS consecutive 8-bit registers of one I2C device
// through an i2c_master. Each register is a one-byte pointer write followed by
// a one-byte read; failed attempts are retried up to MAX_RETRIES times before
// the register is reported with reg_error set and reg_data = 8'hFF.
//   clk_in, reset          : clock, asynchronous active-high reset
//   enable                 : keep sweeping while high
//   address, transfer_start, transfer_continues, data_tx : requests to master
//   transfer_ready, interrupt, transaction_complete, nack,
//   start_err, arbitration_err, address_err, data_rx     : status from master
//   reg_index, reg_data, reg_error, reg_valid : per-register result
//   sweep_done             : strobe with the last register of a sweep
//   busy                   : FSM not in IDLE
module i2c_register_poller
  import i2c_poller_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR   = 7'h6B,
  parameter logic [7:0]  BASE_REG      = 8'h00,
  parameter int unsigned NUM_REGS      = 1,
  parameter int unsigned POLL_INTERVAL = 480000,
  parameter int unsigned MAX_RETRIES   = 3,
  localparam int unsigned IDX_W        = min1_clog2(NUM_REGS)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  output logic [7:0]       address,
  output logic             transfer_start,
  output logic             transfer_continues,
  output logic [7:0]       data_tx,
  input  logic             transfer_ready,
  input  logic             interrupt,
  input  logic             transaction_complete,
  input  logic             nack,
  input  logic             start_err,
  input  logic             arbitration_err,
  input  logic             address_err,
  input  logic [7:0]       data_rx,
  output logic [IDX_W-1:0] reg_index,
  output logic [7:0]       reg_data,
  output logic             reg_valid,
  output logic             reg_error,
  output logic             sweep_done,
  output logic             busy
);

  localparam int unsigned     TIMER_W     = min1_clog2(POLL_INTERVAL);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [3:0]      RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       retry_q, retry_d;
  logic             start_q, start_d;
  logic [IDX_W-1:0] reg_index_q, reg_index_d;
  logic [7:0]       reg_data_q, reg_data_d;
  logic             reg_error_q, reg_error_d;
  logic             timer_load, timer_zero;
  logic             done_evt, err_evt, wr_fail;

  poll_interval_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk_in    (clk_in),
    .reset     (reset),
    .load      (timer_load),
    .load_value(TIMER_W'(POLL_INTERVAL - 1)),
    .zero      (timer_zero)
  );

  assign done_evt = interrupt & transaction_complete;
  assign err_evt  = interrupt & (start_err | arbitration_err | address_err);
  // On the write side a NACK means the device rejected us; on the read side it
  // is the master's own last-byte NACK, so only bus errors count there.
  assign wr_fail  = err_evt | (done_evt & nack);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    start_d     = 1'b0;
    reg_index_d = reg_index_q;
    reg_data_d  = reg_data_q;
    reg_error_d = reg_error_q;
    timer_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (timer_zero && enable) begin
          idx_d   = '0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (transfer_ready) begin
          start_d = 1'b1;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_fail) begin
          state_d = RETRY;
        end else if (done_evt) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (transfer_ready) begin
          start_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (err_evt) begin
          state_d = RETRY;
        end else if (done_evt) begin
          reg_data_d  = data_rx;
          reg_error_d = 1'b0;
          reg_index_d = idx_q;
          state_d     = REPORT;
        end
      end
      RETRY: begin
        if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 4'd1;
          state_d = WR_REQ;
        end else begin
          reg_data_d  = 8'hFF;
          reg_error_d = 1'b1;
          reg_index_d = idx_q;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          timer_load = 1'b1;
          state_d    = IDLE;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = WR_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      start_q     <= 1'b0;
      reg_index_q <= '0;
      reg_data_q  <= '0;
      reg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      start_q     <= start_d;
      reg_index_q <= reg_index_d;
      reg_data_q  <= reg_data_d;
      reg_error_q <= reg_error_d;
    end
  end

  assign address            = {DEVICE_ADDR,
                               ((state_q == RD_REQ) || (state_q == RD_WAIT)) ? MODE_READ
                                                                              : MODE_WRITE};
  assign transfer_start     = start_q;
  assign transfer_continues = 1'b0;
  assign data_tx            = BASE_REG + 8'(idx_q);
  assign reg_index          = reg_index_q;
  assign reg_data           = reg_data_q;
  assign reg_error          = reg_error_q;
  assign reg_valid          = (state_q == REPORT);
  assign sweep_done         = (state_q == REPORT) && (idx_q == LAST_IDX);
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_register_poller.sv
// Directed bench for i2c_register_poller with a behavioural i2c_master/device.
module tb_i2c_register_poller;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] address;
  logic       transfer_start;
  logic       transfer_continues;
  logic [7:0] data_tx;
  logic       transfer_ready;
  logic       interrupt            = 1'b0;
  logic       transaction_complete = 1'b0;
  logic       nack                 = 1'b0;
  logic       start_err            = 1'b0;
  logic       arbitration_err      = 1'b0;
  logic       address_err          = 1'b0;
  logic [7:0] data_rx              = 8'h00;
  logic [1:0] reg_index;
  logic [7:0] reg_data;
  logic       reg_valid;
  logic       reg_error;
  logic       sweep_done;
  logic       busy;

  always #10 clk_in = ~clk_in;

  i2c_register_poller #(
    .DEVICE_ADDR  (7'h6B),
    .BASE_REG     (8'h08),
    .NUM_REGS     (3),
    .POLL_INTERVAL(16),
    .MAX_RETRIES  (2)
  ) dut (
    .clk_in              (clk_in),
    .reset               (reset),
    .enable              (enable),
    .address             (address),
    .transfer_start      (transfer_start),
    .transfer_continues  (transfer_continues),
    .data_tx             (data_tx),
    .transfer_ready      (transfer_ready),
    .interrupt           (interrupt),
    .transaction_complete(transaction_complete),
    .nack                (nack),
    .start_err           (start_err),
    .arbitration_err     (arbitration_err),
    .address_err         (address_err),
    .data_rx             (data_rx),
    .reg_index           (reg_index),
    .reg_data            (reg_data),
    .reg_valid           (reg_valid),
    .reg_error           (reg_error),
    .sweep_done          (sweep_done),
    .busy                (busy)
  );

  // ---------------- master + device model ----------------
  logic       ready_hold = 1'b0;
  logic       mbusy      = 1'b0;
  int         mcnt       = 0;
  logic       mmode      = 1'b0;
  logic [7:0] mdata      = 8'h00;
  logic [7:0] mptr       = 8'h00;
  int         nack_req   = 0;
  int         nack_used  = 0;
  int         arb_req    = 0;
  int         arb_used   = 0;

  function automatic logic [7:0] dev_reg(input logic [7:0] p);
    case (p)
      8'h08:   return 8'hA5;
      8'h09:   return 8'h3C;
      8'h0A:   return 8'h01;
      default: return 8'hEE;
    endcase
  endfunction

  assign transfer_ready = !mbusy && !ready_hold;

  always @(posedge clk_in) begin
    interrupt            <= 1'b0;
    transaction_complete <= 1'b0;
    nack                 <= 1'b0;
    start_err            <= 1'b0;
    arbitration_err      <= 1'b0;
    address_err          <= 1'b0;
    if (transfer_start) begin
      mbusy <= 1'b1;
      mcnt  <= 4;
      mmode <= address[0];
      mdata <= data_tx;
    end else if (mbusy) begin
      if (mcnt > 0) begin
        mcnt <= mcnt - 1;
      end else begin
        mbusy     <= 1'b0;
        interrupt <= 1'b1;
        if (!mmode) begin
          transaction_complete <= 1'b1;
          if (nack_used < nack_req) begin
            nack      <= 1'b1;
            nack_used <= nack_used + 1;
          end else begin
            mptr <= mdata;
          end
        end else if (arb_used < arb_req) begin
          arbitration_err <= 1'b1;
          arb_used        <= arb_used + 1;
        end else begin
          transaction_complete <= 1'b1;
          nack                 <= 1'b1;
          data_rx              <= dev_reg(mptr);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int   wr_starts   = 0;
  int   rd_starts   = 0;
  int   done_cnt    = 0;
  int   violations  = 0;
  logic outstanding = 1'b0;

  always @(negedge clk_in) begin
    if (reset) begin
      outstanding <= 1'b0;
    end else if (transfer_start) begin
      if (outstanding) violations <= violations + 1;
      outstanding <= 1'b1;
      if (address[0]) rd_starts <= rd_starts + 1;
      else            wr_starts <= wr_starts + 1;
    end else if (interrupt && (transaction_complete | start_err | arbitration_err | address_err)) begin
      outstanding <= 1'b0;
    end
    if (sweep_done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (reg_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Wait for a start pulse; match_rd selects read-only, match_ptr a data_tx value.
  task automatic wait_start(input bit match_rd, input bit match_ptr, input logic [7:0] ptr,
                            input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (transfer_start && (!match_rd || address[0]) && (!match_ptr || data_tx == ptr)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    enable = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_in);
      if (!busy) break;
    end
    check("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    {31'd0, busy},           32'd0);
    check({tag, "_start"},   {31'd0, transfer_start}, 32'd0);
    check({tag, "_addr"},    {24'd0, address},        32'hD6);
    check({tag, "_data_tx"}, {24'd0, data_tx},        32'h08);
    check({tag, "_index"},   {30'd0, reg_index},      32'd0);
    check({tag, "_data"},    {24'd0, reg_data},       32'd0);
    check({tag, "_valid"},   {31'd0, reg_valid},      32'd0);
    check({tag, "_error"},   {31'd0, reg_error},      32'd0);
    check({tag, "_done"},    {31'd0, sweep_done},     32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int low, w0, r0, s0, d0, hi, vcnt;
    logic [7:0] exp_data [3];
    exp_data[0] = 8'hA5;
    exp_data[1] = 8'h3C;
    exp_data[2] = 8'h01;

    repeat (3) @(negedge clk_in);
    check_reset_outputs("rst");
    check("rst_cont", {31'd0, transfer_continues}, 32'd0);

    // Full sweep of three registers, then the idle interval.
    reset  = 1'b0;
    enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_valid(500, ok);
      check("sweep_tmo", {31'd0, ok}, 32'd1);
      check("sweep_idx", {30'd0, reg_index}, r);
      check("sweep_data", {24'd0, reg_data}, {24'd0, exp_data[r]});
      check("sweep_err", {31'd0, reg_error}, 32'd0);
      check("sweep_done", {31'd0, sweep_done}, (r == 2) ? 32'd1 : 32'd0);
    end
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (!busy) low++;
      else break;
    end
    check("interval_len", low, 16);
    drain();

    // Write NACK on every attempt: three write starts, then an error report.
    w0 = wr_starts;
    r0 = rd_starts;
    nack_req = nack_req + 3;
    enable = 1'b1;
    wait_valid(1000, ok);
    check("nack_tmo", {31'd0, ok}, 32'd1);
    check("nack_idx", {30'd0, reg_index}, 32'd0);
    check("nack_err", {31'd0, reg_error}, 32'd1);
    check("nack_data", {24'd0, reg_data}, 32'hFF);
    check("nack_wr_starts", wr_starts - w0, 3);
    check("nack_rd_starts", rd_starts - r0, 0);
    wait_valid(500, ok);
    check("nack_next_tmo", {31'd0, ok}, 32'd1);
    check("nack_next_idx", {30'd0, reg_index}, 32'd1);
    check("nack_next_err", {31'd0, reg_error}, 32'd0);
    check("nack_next_data", {24'd0, reg_data}, 32'h3C);
    drain();

    // One arbitration error during the read: a single retry, then success.
    w0 = wr_starts;
    r0 = rd_starts;
    arb_req = arb_req + 1;
    enable = 1'b1;
    wait_valid(1000, ok);
    check("arb_tmo", {31'd0, ok}, 32'd1);
    check("arb_idx", {30'd0, reg_index}, 32'd0);
    check("arb_err", {31'd0, reg_error}, 32'd0);
    check("arb_data", {24'd0, reg_data}, 32'hA5);
    check("arb_wr_starts", wr_starts - w0, 2);
    check("arb_rd_starts", rd_starts - r0, 2);
    drain();

    // transfer_ready held low for 50 cycles in WR_REQ.
    ready_hold = 1'b1;
    s0 = wr_starts + rd_starts;
    enable = 1'b1;
    repeat (50) @(negedge clk_in);
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_no_start", wr_starts + rd_starts - s0, 0);
    ready_hold = 1'b0;
    @(negedge clk_in);
    check("hold_start_hi", {31'd0, transfer_start}, 32'd1);
    check("hold_start_addr", {24'd0, address}, 32'hD6);
    check("hold_start_ptr", {24'd0, data_tx}, 32'h08);
    @(negedge clk_in);
    check("hold_start_lo", {31'd0, transfer_start}, 32'd0);

    // Reset asserted in the first RD_WAIT cycle, while transfer_start is high.
    wait_start(1'b1, 1'b0, 8'h00, 500, ok);
    check("rdwait_tmo", {31'd0, ok}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    wait_start(1'b0, 1'b0, 8'h00, 500, ok);
    check("postrst_tmo", {31'd0, ok}, 32'd1);
    check("postrst_addr", {24'd0, address}, 32'hD6);
    check("postrst_ptr", {24'd0, data_tx}, 32'h08);

    // Drop enable while reading index 1.
    wait_start(1'b1, 1'b1, 8'h09, 1000, ok);
    check("idx1_rd_tmo", {31'd0, ok}, 32'd1);
    enable = 1'b0;
    d0 = done_cnt;
    wait_valid(500, ok);
    check("stop_tmo", {31'd0, ok}, 32'd1);
    check("stop_idx", {30'd0, reg_index}, 32'd1);
    check("stop_data", {24'd0, reg_data}, 32'h3C);
    check("stop_done", {31'd0, sweep_done}, 32'd0);
    hi   = 0;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (busy) hi++;
      if (reg_valid) vcnt++;
    end
    check("stop_parked", hi, 0);
    check("stop_no_valid", vcnt, 0);
    check("stop_no_sweep_done", done_cnt - d0, 0);

    check("start_protocol", violations, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
